event_encoder: RTL and testbench

//   Sequential 8:3 priority encoder. It is the inverse of the team's 3:8 one-hot decoder.

---
 rtl/event_encoder_if.sv | 12 +
 rtl/event_encoder.sv | 72 +++++++
 tb/tb_event_encoder.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/event_encoder_if.sv
// rtl/event_encoder_if.sv - valid/ready stream carrying the encoded event index
// The encoder drives code/valid; the consumer returns ready.
interface event_encoder_if #(
    parameter int W = 3
);
    logic [W-1:0] code;
    logic         valid;
    logic         ready;

    modport master (output code, output valid, input ready);
    modport slave  (input code, input valid, output ready);
endinterface

// File: rtl/event_encoder.sv
// rtl/event_encoder.sv - sequential N:log2(N) priority encoder of latched one-hot events
// Pending events drain lowest index first through a single registered output stage.
module event_encoder #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        req,
    event_encoder_if.master     evt,
    output logic [N-1:0]        pending,
    output logic                overflow,
    input  logic                clr_ovf
);

    logic [N-1:0] r_pending;
    logic [W-1:0] r_code;
    logic         r_valid;
    logic         r_overflow;

    logic         w_can_load;
    logic         w_load;
    logic [N-1:0] w_lowbit;
    logic [N-1:0] w_mask;
    logic [W-1:0] w_idx;
    logic         w_ovf_set;

    // Isolate the lowest set bit with the two's-complement trick.
    assign w_lowbit   = r_pending & ((~r_pending) + {{(N-1){1'b0}}, 1'b1});
    assign w_can_load = !r_valid || evt.ready;
    assign w_load     = w_can_load && (|r_pending);
    assign w_mask     = w_load ? w_lowbit : '0;
    // A bit being loaded this edge frees its slot, so a coincident req is a new event.
    assign w_ovf_set  = |(req & r_pending & ~w_mask);

    always_comb begin
        w_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_idx = W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending  <= '0;
            r_code     <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_mask) | req;
            if (w_load) begin
                r_code  <= w_idx;
                r_valid <= 1'b1;
            end else if (w_can_load) begin
                r_valid <= 1'b0;
            end
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign evt.code  = r_code;
    assign evt.valid = r_valid;
    assign pending   = r_pending;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_event_encoder.sv
// tb/tb_event_encoder.sv - self-checking bench for event_encoder
// Directed scenarios followed by random traffic, checked against an event-set model.
module tb_event_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] pending;
    logic       overflow;
    logic       clr_ovf;

    event_encoder_if #(.W(3)) evt_if ();

    event_encoder #(.N(8), .W(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .evt      (evt_if),
        .pending  (pending),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: set of pending indices, one output slot, sticky loss flag.
    logic [7:0] m_pend;
    logic       m_valid;
    logic [2:0] m_code;
    logic       m_ovf;
    logic [2:0] got[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest(input logic [7:0] p);
        for (int i = 0; i < 8; i++) begin
            if (p[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_pend  = 8'h00;
        m_valid = 1'b0;
        m_code  = 3'd0;
        m_ovf   = 1'b0;
    endtask

    task automatic step(input logic [7:0] r, input logic rd, input logic c);
        logic [7:0] old;
        logic [7:0] mask;
        logic       lost;
        int         idx;
        req           = r;
        evt_if.ready  = rd;
        clr_ovf       = c;
        if (evt_if.valid && rd) got.push_back(evt_if.code);
        old  = m_pend;
        mask = 8'h00;
        if (!m_valid || rd) begin
            if (old != 8'h00) begin
                idx     = lowest(old);
                m_code  = 3'(idx);
                m_valid = 1'b1;
                mask    = 8'(1) << idx;
            end else begin
                m_valid = 1'b0;
            end
        end
        lost = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (r[i] && old[i] && !mask[i]) lost = 1'b1;
        end
        if (lost) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
        m_pend = (old & ~mask) | r;
        @(posedge clk);
        #1;
        check("valid",    32'(evt_if.valid), 32'(m_valid));
        check("code",     32'(evt_if.code),  32'(m_code));
        check("pending",  32'(pending),      32'(m_pend));
        check("overflow", 32'(overflow),     32'(m_ovf));
    endtask

    task automatic check_got(input string tag, input logic [2:0] exp[$]);
        check({tag, "_count"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            check(tag, 32'(got[i]), 32'(exp[i]));
        end
        got.delete();
    endtask

    initial begin
        rst          = 1'b1;
        req          = 8'h00;
        clr_ovf      = 1'b0;
        evt_if.ready = 1'b0;
        model_reset();
        #1;
        check("reset_valid",    32'(evt_if.valid), 32'd0);
        check("reset_code",     32'(evt_if.code),  32'd0);
        check("reset_pending",  32'(pending),      32'd0);
        check("reset_overflow", 32'(overflow),     32'd0);
        #7 rst = 1'b0;

        // Single event: code 3 appears two edges after the strobe, for one cycle.
        step(8'h08, 1'b1, 1'b0);
        check("single_not_yet", 32'(evt_if.valid), 32'd0);
        step(8'h00, 1'b1, 1'b0);
        check("single_code", 32'(evt_if.code), 32'd3);
        step(8'h00, 1'b1, 1'b0);
        check("single_gone", 32'(evt_if.valid), 32'd0);
        check_got("single", '{3'd3});

        // Burst ordering
        step(8'hC5, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(8'h00, 1'b1, 1'b0);
        check("burst_idle", 32'(evt_if.valid), 32'd0);
        check_got("burst", '{3'd0, 3'd2, 3'd6, 3'd7});

        // Backpressure
        step(8'h12, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(8'h00, 1'b0, 1'b0);
        check("bp_code", 32'(evt_if.code), 32'd1);
        check("bp_pending", 32'(pending), 32'h10);
        step(8'h00, 1'b1, 1'b0);
        check("bp_next", 32'(evt_if.code), 32'd4);
        step(8'h00, 1'b1, 1'b0);
        check("bp_idle", 32'(evt_if.valid), 32'd0);
        check_got("bp", '{3'd1, 3'd4});

        // Overflow: output stage busy, bit 7 strobed twice
        step(8'h01, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        step(8'h80, 1'b0, 1'b0);
        step(8'h80, 1'b0, 1'b0);
        check("ovf_set", 32'(overflow), 32'd1);
        for (int i = 0; i < 4; i++) step(8'h00, 1'b1, 1'b0);
        check_got("ovf", '{3'd0, 3'd7});
        step(8'h00, 1'b1, 1'b1);
        check("ovf_clr", 32'(overflow), 32'd0);

        // Set wins on the load edge
        step(8'h01, 1'b1, 1'b0);
        step(8'h01, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0);
        check("setwin_ovf", 32'(overflow), 32'd0);
        check_got("setwin", '{3'd0, 3'd0});

        // Random traffic, including clr_ovf racing new losses
        for (int i = 0; i < 400; i++) begin
            step(8'($urandom & $urandom & $urandom), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 7) == 0));
        end
        got.delete();

        // Asynchronous reset mid-stream
        step(8'hA5, 1'b0, 1'b0);
        step(8'h01, 1'b0, 1'b0);
        step(8'h80, 1'b0, 1'b0);
        check("pre_rst_pending", 32'(pending), 32'hA5);
        check("pre_rst_valid", 32'(evt_if.valid), 32'd1);
        check("pre_rst_ovf", 32'(overflow), 32'd1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("async_pending",  32'(pending),      32'd0);
        check("async_valid",    32'(evt_if.valid), 32'd0);
        check("async_overflow", 32'(overflow),     32'd0);
        #1 rst = 1'b0;
        step(8'h00, 1'b1, 1'b0);
        step(8'h40, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0);
        check("post_rst_code", 32'(evt_if.code), 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
